// File: rtl/adc_overload_detector.sv
// -----------------------------------------------------------------------------
// adc_overload_detector
//
// Saturation detector for the AGC's external overload input. Counts near-rail
// ADC samples over fixed windows of WINDOW cycles. A window holding at least
// HIT_MIN hits raises `overload`. A failing window starts a HOLD-cycle
// hold-off before the flag is released. A passing window during hold-off
// keeps the flag high.
//
// Ports
//   clk              in   sole clock, all logic on posedge
//   RESETn           in   synchronous active-low reset
//   amplified_signal in   ADC sample (offset-binary), one per cycle
//   enable           in   detector run; 0 returns to IDLE and drops counters
//   overload         out  registered saturation flag
//   hit_count_out    out  debug: hits accumulated in the current window
//   window_done      out  debug: one-cycle pulse after each evaluation edge
//
// Handshake: there is no valid/ready pair. A sample is consumed on every
// rising edge while enabled, and the outputs are valid every cycle.
// -----------------------------------------------------------------------------
module adc_overload_detector #(
    parameter int                WIDTH     = 16,
    parameter int                WINDOW    = 16,
    parameter int                HIT_MIN   = 4,
    parameter int                HOLD      = 8,
    parameter logic [WIDTH-1:0]  HI_THRESH = 16'hFFF0,
    parameter logic [WIDTH-1:0]  LO_THRESH = 16'h000F,
    localparam int               CW        = $clog2(WINDOW + 1),
    localparam int               WW        = $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             RESETn,
    input  logic [WIDTH-1:0] amplified_signal,
    input  logic             enable,
    output logic             overload,
    output logic [CW-1:0]    hit_count_out,
    output logic             window_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_OVER    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   win_q, win_d;
    logic [CW-1:0]   hit_q, hit_d;
    logic [7:0]      hold_q, hold_d;
    logic            overload_q, overload_d;
    logic            done_q, done_d;

    logic            hit;
    logic            eval;
    logic [CW-1:0]   total;
    logic            pass;
    logic [WW-1:0]   win_step;
    logic [CW-1:0]   hit_step;

    // Hit detection and window evaluation are purely combinational; the
    // evaluating edge includes its own sample in the window total.
    assign hit   = (amplified_signal >= HI_THRESH) || (amplified_signal <= LO_THRESH);
    assign eval  = (win_q == WW'(WINDOW - 1));
    assign total = hit_q + CW'(hit);
    assign pass  = (total >= CW'(HIT_MIN));

    // Counter advance shared by every running state: wrap and clear on the
    // evaluation edge, otherwise step.
    assign win_step = eval ? '0 : win_q + 1'b1;
    assign hit_step = eval ? '0 : total;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        hit_d   = hit_q;
        hold_d  = hold_q;
        done_d  = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            win_d   = '0;
            hit_d   = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Counters stay at zero; window 1 starts with the next sample.
                    state_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    win_d  = win_step;
                    hit_d  = hit_step;
                    done_d = eval;
                    if (eval && pass) begin
                        state_d = ST_OVER;
                    end
                end
                ST_OVER: begin
                    win_d  = win_step;
                    hit_d  = hit_step;
                    done_d = eval;
                    if (eval && !pass) begin
                        if (HOLD == 0) begin
                            state_d = ST_CLEAR;
                        end else begin
                            state_d = ST_RELEASE;
                            hold_d  = 8'(HOLD - 1);
                        end
                    end
                end
                ST_RELEASE: begin
                    win_d  = win_step;
                    hit_d  = hit_step;
                    done_d = eval;
                    // A passing window beats hold-off expiry on the same edge.
                    if (eval && pass) begin
                        state_d = ST_OVER;
                        hold_d  = '0;
                    end else if (hold_q == 8'd0) begin
                        state_d = ST_CLEAR;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    win_d   = '0;
                    hit_d   = '0;
                    hold_d  = '0;
                end
            endcase
        end

        overload_d = (state_d == ST_OVER) || (state_d == ST_RELEASE);
    end

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            hit_q      <= '0;
            hold_q     <= '0;
            overload_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            hit_q      <= hit_d;
            hold_q     <= hold_d;
            overload_q <= overload_d;
            done_q     <= done_d;
        end
    end

    assign overload      = overload_q;
    assign window_done   = done_q;
    assign hit_count_out = hit_q;

endmodule

// File: tb/tb_adc_overload_detector.sv
// -----------------------------------------------------------------------------
// tb_adc_overload_detector
//
// Two detector instances share one input stream: the default one (HOLD=8)
// and one with HOLD=20 for the long hold-off case. The driver pushes the
// expected outputs of both into one queue per edge; a monitor pops and
// compares one entry #1 after every rising edge.
// -----------------------------------------------------------------------------
module tb_adc_overload_detector;

    localparam int WIDTH   = 16;
    localparam int WINDOW  = 16;
    localparam int HIT_MIN = 4;
    localparam int CW      = $clog2(WINDOW + 1);
    localparam int EW      = CW + 2;
    localparam logic [15:0] HI = 16'hFFF0;
    localparam logic [15:0] LO = 16'h000F;

    logic             clk;
    logic             RESETn;
    logic [WIDTH-1:0] amplified_signal;
    logic             enable;

    logic             overload0, overload1;
    logic [CW-1:0]    hit_count0, hit_count1;
    logic             done0, done1;

    int checks   = 0;
    int failures = 0;

    logic [2*EW-1:0] exp_q[$];

    // Reference model: window position, hit tally, flag and the edge at which
    // a pending release takes effect.
    int   hold_of[2] = '{8, 20};
    bit   m_active[2];
    int   m_pos[2];
    int   m_hits[2];
    bit   m_flag[2];
    int   m_drop[2];
    int   cyc;

    adc_overload_detector u_dut0 (
        .clk              (clk),
        .RESETn           (RESETn),
        .amplified_signal (amplified_signal),
        .enable           (enable),
        .overload         (overload0),
        .hit_count_out    (hit_count0),
        .window_done      (done0)
    );

    adc_overload_detector #(.HOLD(20)) u_dut1 (
        .clk              (clk),
        .RESETn           (RESETn),
        .amplified_signal (amplified_signal),
        .enable           (enable),
        .overload         (overload1),
        .hit_count_out    (hit_count1),
        .window_done      (done1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [EW-1:0] model_step(input int i, input logic rstn,
                                                 input logic en, input logic [15:0] s);
        logic done;
        bit   pass;
        done = 1'b0;
        if (!rstn || !en) begin
            m_active[i] = 0;
            m_pos[i]    = 0;
            m_hits[i]   = 0;
            m_flag[i]   = 0;
            m_drop[i]   = -1;
        end else if (!m_active[i]) begin
            m_active[i] = 1;
        end else begin
            if (s >= HI || s <= LO) m_hits[i] = m_hits[i] + 1;
            m_pos[i] = m_pos[i] + 1;
            if (m_pos[i] == WINDOW) begin
                done = 1'b1;
                pass = (m_hits[i] >= HIT_MIN);
                m_pos[i]  = 0;
                m_hits[i] = 0;
                if (pass) begin
                    m_flag[i] = 1;
                    m_drop[i] = -1;
                end else if (m_flag[i] && m_drop[i] < 0) begin
                    if (hold_of[i] == 0) m_flag[i] = 0;
                    else m_drop[i] = cyc + hold_of[i];
                end
            end
            if (m_drop[i] >= 0 && cyc == m_drop[i]) begin
                m_flag[i] = 0;
                m_drop[i] = -1;
            end
        end
        return {m_flag[i], done, CW'(m_hits[i])};
    endfunction

    // driver
    task automatic cycle(input logic rstn, input logic en, input logic [15:0] s);
        logic [EW-1:0] e0, e1;
        @(negedge clk);
        RESETn           = rstn;
        enable           = en;
        amplified_signal = s;
        @(posedge clk);
        cyc = cyc + 1;
        e0 = model_step(0, rstn, en, s);
        e1 = model_step(1, rstn, en, s);
        exp_q.push_back({e1, e0});
    endtask

    task automatic feed(input int n, input logic [15:0] s);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b1, s);
    endtask

    // One full window: `hits` copies of hv first, then mid-scale.
    task automatic window_hits(input int hits, input logic [15:0] hv);
        feed(hits, hv);
        feed(WINDOW - hits, 16'h8000);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 16'hFFFF);
    endtask

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // scoreboard monitor
    initial begin
        logic [2*EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("overload_h8",  CW'(overload0),  CW'(e[EW-1]));
                check("done_h8",      CW'(done0),      CW'(e[EW-2]));
                check("hitcnt_h8",    hit_count0,      e[CW-1:0]);
                check("overload_h20", CW'(overload1),  CW'(e[2*EW-1]));
                check("done_h20",     CW'(done1),      CW'(e[2*EW-2]));
                check("hitcnt_h20",   hit_count1,      e[EW+CW-1:EW]);
            end
        end
    end

    // stimulus
    initial begin
        int dens;
        logic [15:0] s;
        logic rstn, en;
        cyc              = 0;
        RESETn           = 1'b0;
        enable           = 1'b0;
        amplified_signal = '0;
        for (int i = 0; i < 2; i++) m_drop[i] = -1;

        // reset, then disabled with full-scale input
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 16'hFFFF);
        idle(5);

        // assert at threshold, then one hit short
        cycle(1'b1, 1'b1, 16'h8000);
        window_hits(4, 16'hFFF0);
        feed(4, 16'h8000);
        idle(2);
        cycle(1'b1, 1'b1, 16'h8000);
        window_hits(3, 16'hFFF0);
        idle(2);

        // lower rail and boundaries
        cycle(1'b1, 1'b1, 16'h8000);
        window_hits(4, 16'h000F);
        idle(2);
        cycle(1'b1, 1'b1, 16'h8000);
        feed(3, 16'h000F);
        feed(2, 16'h0010);
        feed(2, 16'hFFEF);
        feed(WINDOW - 7, 16'h8000);
        window_hits(4, 16'h0000);
        idle(2);

        // hold release; window 3 passes at edge 48 (inside HOLD=20 hold-off)
        cycle(1'b1, 1'b1, 16'h8000);
        window_hits(4, 16'hFFFF);
        feed(WINDOW, 16'h8000);
        feed(WINDOW - 4, 16'h8000);
        feed(4, 16'hFFFF);
        feed(3 * WINDOW, 16'h8000);
        idle(2);

        // enable drop mid-operation, then a fresh window
        cycle(1'b1, 1'b1, 16'h8000);
        window_hits(4, 16'hFFF0);
        feed(3, 16'hFFF0);
        cycle(1'b1, 1'b0, 16'hFFF0);
        cycle(1'b1, 1'b1, 16'hFFF0);
        feed(WINDOW - 4, 16'h8000);
        feed(4, 16'hFFF0);
        feed(4, 16'h8000);

        // reset mid-window with 3 hits accumulated
        idle(2);
        cycle(1'b1, 1'b1, 16'h8000);
        feed(3, 16'hFFFF);
        feed(6, 16'h8000);
        cycle(1'b0, 1'b1, 16'h8000);
        cycle(1'b1, 1'b1, 16'h8000);
        window_hits(3, 16'hFFFF);
        window_hits(1, 16'hFFFF);
        feed(WINDOW - 4, 16'h8000);
        feed(4, 16'hFFFF);
        feed(2, 16'h8000);

        // randomized: per-window hit density, rare enable drops and resets
        dens = 0;
        for (int k = 0; k < 4000; k++) begin
            if (k % WINDOW == 0) dens = $urandom_range(0, 45);
            if ($urandom_range(0, 99) < dens) begin
                if ($urandom_range(0, 1) == 0) s = 16'hFFF0 + 16'($urandom_range(0, 15));
                else s = 16'($urandom_range(0, 15));
            end else begin
                case ($urandom_range(0, 3))
                    0:       s = 16'h0010;
                    1:       s = 16'hFFEF;
                    default: s = 16'($urandom_range(16'h0010, 16'hFFEF));
                endcase
            end
            rstn = ($urandom_range(0, 599) != 0);
            en   = ($urandom_range(0, 249) != 0);
            cycle(rstn, en, s);
        end
        idle(2);

        // drain, bounded
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
